// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
// Pure declarations, no latency, no flow control.
// Imported by the arbiter top and its watchdog counter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        BUSY_I = ST_BUSY_I,
        BUSY_D = ST_BUSY_D
    } arb_state_t;

    // Tie-break: data wins unless it was the last port served.
    function automatic logic pick_data(input logic i_req, input logic d_req, input logic last_d);
        return d_req && (!i_req || !last_d);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// No logic, no latency; request/grant handshakes are owned by the arbiter.
// master = arbiter side, slave = requesters plus memory model.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          i_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic [DW-1:0] m_rdata;
    logic          sel_data;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_ack, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata, sel_data
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output m_ack, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata, sel_data
    );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Busy-phase watchdog: clearable saturating up-counter flagging TIMEOUT cycles.
// expired is combinational in the cycle the count would reach TIMEOUT.
// No backpressure; inc is ignored while clr is high.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Flag on the cycle whose increment lands on TIMEOUT so the exit
    // happens after exactly TIMEOUT unacknowledged busy cycles.
    assign expired = inc && !clr && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, round-robin on ties.
// Grant is combinational in IDLE; completion/abort pulses one cycle after ack/timeout.
// Requesters hold req until grant; memory side holds m_req until m_ack or watchdog expiry.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.master bus
);

    arb_state_t    state;
    logic          last_d;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          i_rvalid_q, d_rvalid_q, i_err_q, d_err_q;
    logic [DW-1:0] i_rdata_q, d_rdata_q;

    logic busy;
    logic grant_i, grant_d;
    logic wd_expired;

    assign busy = (state != IDLE);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (pick_data(bus.i_req, bus.d_req, last_d)) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy),
        .inc     (busy && !bus.m_ack),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_d     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        addr_q  <= bus.d_addr;
                        we_q    <= bus.d_we;
                        wdata_q <= bus.d_wdata;
                    end else if (grant_i) begin
                        state   <= BUSY_I;
                        addr_q  <= bus.i_addr;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack in the expiry cycle still completes normally.
                    if (bus.m_ack) begin
                        state  <= IDLE;
                        last_d <= (state == BUSY_D);
                        if (state == BUSY_D) begin
                            d_rdata_q  <= bus.m_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            i_rdata_q  <= bus.m_rdata;
                            i_rvalid_q <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state   <= IDLE;
                        last_d  <= (state == BUSY_D);
                        d_err_q <= (state == BUSY_D);
                        i_err_q <= (state == BUSY_I);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt    = grant_i;
    assign bus.d_gnt    = grant_d;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_err    = i_err_q;
    assign bus.d_err    = d_err_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

    assign bus.m_req    = busy;
    assign bus.m_we     = we_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;
    assign bus.sel_data = (state == BUSY_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions
// plus hand sequences for ties, timeout with pending request and mid-op reset.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_i;

    typedef struct {
        bit          use_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;   // busy cycle carrying m_ack, 0 = never
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        bit tmo;
        tmo = (v.ack_at == 0);
        @(negedge clk);
        bus.i_req   = !v.use_d;
        bus.i_addr  = v.addr;
        bus.d_req   = v.use_d;
        bus.d_we    = v.we;
        bus.d_addr  = v.addr;
        bus.d_wdata = v.wdata;
        #1;
        chk("i_gnt", 64'(bus.i_gnt), 64'(!v.use_d));
        chk("d_gnt", 64'(bus.d_gnt), 64'(v.use_d));
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            chk("m_req_busy", 64'(bus.m_req), 64'd1);
            chk("m_addr", 64'(bus.m_addr), 64'(v.addr));
            chk("m_we", 64'(bus.m_we), 64'(v.use_d && v.we));
            chk("sel_data", 64'(bus.sel_data), 64'(v.use_d));
            if (v.use_d && v.we) chk("m_wdata", 64'(bus.m_wdata), 64'(v.wdata));
            if (c == v.ack_at) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = v.we ? 32'h0 : v.rdata;
                break;
            end
        end
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("m_req_done", 64'(bus.m_req), 64'd0);
        chk("i_rvalid", 64'(bus.i_rvalid), 64'(!v.use_d && !tmo));
        chk("d_rvalid", 64'(bus.d_rvalid), 64'(v.use_d && !tmo));
        chk("i_err", 64'(bus.i_err), 64'(!v.use_d && tmo));
        chk("d_err", 64'(bus.d_err), 64'(v.use_d && tmo));
        if (!v.use_d && !tmo) last_i = v.rdata;
        if (!v.use_d) chk("i_rdata", 64'(bus.i_rdata), 64'(last_i));
        if (v.use_d && !v.we && !tmo) chk("d_rdata", 64'(bus.d_rdata), 64'(v.rdata));
        @(negedge clk);
        chk("pulses_clear", 64'({bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ack = 1'b0; bus.m_rdata = '0;
        last_i = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        32'h00500093, 1};
        vecs[1] = '{1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 32'h0,        3};
        vecs[2] = '{1'b1, 1'b0, 32'h3000, 32'h0,        32'h12345678, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h104,  32'h0,        32'h0BADC0DE, 0};
        vecs[4] = '{1'b0, 1'b0, 32'h108,  32'h0,        32'hCAFEF00D, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h2004, 32'h0F0F0F0F, 32'h0,        0};
        vecs[6] = '{1'b1, 1'b0, 32'h3008, 32'h0,        32'hA5A5A5A5, 4};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m", 64'({bus.m_req, bus.m_we, bus.sel_data}), 64'd0);
        chk("rst_m_addr", 64'(bus.m_addr), 64'd0);
        chk("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
        chk("rst_pulses", 64'({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err}), 64'd0);
        chk("rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'd0);
        rst = 1'b0;

        // Tie from reset: data first, then fetch, then data again
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h200;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
        #1;
        chk("tie1_d_gnt", 64'(bus.d_gnt), 64'd1);
        chk("tie1_i_gnt", 64'(bus.i_gnt), 64'd0);
        @(negedge clk);
        bus.d_req = 1'b0;
        chk("tie1_sel", 64'(bus.sel_data), 64'd1);
        chk("tie1_addr", 64'(bus.m_addr), 64'h400);
        chk("tie1_i_wait", 64'(bus.i_gnt), 64'd0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h11111111;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("tie1_d_rvalid", 64'(bus.d_rvalid), 64'd1);
        chk("tie1_d_rdata", 64'(bus.d_rdata), 64'h11111111);
        chk("tie1_i_gnt_after", 64'(bus.i_gnt), 64'd1);
        @(negedge clk);
        bus.i_req = 1'b0;
        chk("tie1_i_sel", 64'(bus.sel_data), 64'd0);
        chk("tie1_i_addr", 64'(bus.m_addr), 64'h200);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h22222222;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("tie1_i_rvalid", 64'(bus.i_rvalid), 64'd1);
        chk("tie1_i_rdata", 64'(bus.i_rdata), 64'h22222222);
        last_i = 32'h22222222;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        #1;
        chk("tie2_d_gnt", 64'(bus.d_gnt), 64'd1);
        chk("tie2_i_gnt", 64'(bus.i_gnt), 64'd0);
        @(negedge clk);
        bus.d_req = 1'b0;
        bus.m_ack = 1'b1; bus.m_rdata = 32'h33333333;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("tie2_d_rvalid", 64'(bus.d_rvalid), 64'd1);
        chk("tie2_i_gnt_after", 64'(bus.i_gnt), 64'd1);
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.m_ack = 1'b1; bus.m_rdata = 32'h44444444;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("tie2_i_rvalid", 64'(bus.i_rvalid), 64'd1);
        last_i = 32'h44444444;

        // Single-requester vector table
        for (int k = 0; k < 7; k++) run_txn(vecs[k]);

        // Fetch timeout with a data request arriving mid-flight
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h500;
        #1;
        chk("to_i_gnt", 64'(bus.i_gnt), 64'd1);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            bus.i_req = 1'b0;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
            chk("to_busy_m_req", 64'(bus.m_req), 64'd1);
            chk("to_busy_d_gnt", 64'(bus.d_gnt), 64'd0);
        end
        @(negedge clk);
        chk("to_i_err", 64'(bus.i_err), 64'd1);
        chk("to_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        chk("to_d_gnt", 64'(bus.d_gnt), 64'd1);
        @(negedge clk);
        bus.d_req = 1'b0;
        chk("to_d_sel", 64'(bus.sel_data), 64'd1);
        chk("to_d_addr", 64'(bus.m_addr), 64'h600);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h55555555;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("to_d_rvalid", 64'(bus.d_rvalid), 64'd1);
        chk("to_d_rdata", 64'(bus.d_rdata), 64'h55555555);

        // Reset in the middle of BUSY_D
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
        #1;
        chk("rm_d_gnt", 64'(bus.d_gnt), 64'd1);
        @(negedge clk);
        bus.d_req = 1'b0;
        chk("rm_busy_m_req", 64'(bus.m_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_m_req", 64'(bus.m_req), 64'd0);
        chk("rm_sel", 64'(bus.sel_data), 64'd0);
        chk("rm_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_idle_m_req", 64'(bus.m_req), 64'd0);
        chk("rm_no_rvalid", 64'(bus.d_rvalid), 64'd0);
        bus.i_req = 1'b1; bus.i_addr = 32'h800;
        bus.d_req = 1'b1; bus.d_addr = 32'h900;
        #1;
        chk("rm_tie_d_gnt", 64'(bus.d_gnt), 64'd1);
        chk("rm_tie_i_gnt", 64'(bus.i_gnt), 64'd0);
        @(negedge clk);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        bus.m_ack = 1'b1; bus.m_rdata = 32'h66666666;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("rm_d_rvalid_after", 64'(bus.d_rvalid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
